// File: rtl/sprite_fetch_scheduler.sv
// Shares one sprite ROM / palette ROM pair among NUM_SPR sprites: picks the highest-priority
// sprite under the beam, issues its texel address and delays hit/id/coords to meet the palette.
module sprite_fetch_scheduler #(
  parameter int NUM_SPR = 3,
  parameter int ADDR_W  = 19,
  parameter int ROM_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pix_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_id,
  input  logic              cfg_en,
  input  logic [9:0]        cfg_x,
  input  logic [9:0]        cfg_y,
  input  logic [6:0]        cfg_w,
  input  logic [6:0]        cfg_h,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              cfg_pending,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              hit_out,
  output logic [1:0]        hit_id,
  output logic [9:0]        X_out,
  output logic [9:0]        Y_out
);

  typedef struct packed {
    logic              en;
    logic [9:0]        x;
    logic [9:0]        y;
    logic [6:0]        w;
    logic [6:0]        h;
    logic [ADDR_W-1:0] base;
  } spr_cfg_t;

  localparam logic [2:0] SPR_LIM = 3'(NUM_SPR);

  // Edge sums are carried in 11 bits so a sprite hanging off the right/bottom clips instead of wrapping.
  function automatic logic spr_hit(spr_cfg_t c, logic [9:0] px, logic [9:0] py);
    logic [10:0] x_end;
    logic [10:0] y_end;
    x_end = {1'b0, c.x} + {4'b0, c.w};
    y_end = {1'b0, c.y} + {4'b0, c.h};
    return c.en && (c.w != 7'd0) && (c.h != 7'd0) &&
           (px >= c.x) && ({1'b0, px} < x_end) &&
           (py >= c.y) && ({1'b0, py} < y_end);
  endfunction

  function automatic logic [ADDR_W-1:0] fetch_addr(logic [ADDR_W-1:0] base, logic [9:0] dy,
                                                   logic [6:0] w, logic [9:0] dx);
    logic [16:0] prod;
    prod = 17'(dy) * 17'(w);
    return base + ADDR_W'(prod) + ADDR_W'(dx);
  endfunction

  spr_cfg_t             shadow [NUM_SPR];
  spr_cfg_t             active [NUM_SPR];
  spr_cfg_t             cfg_in;
  logic                 cfg_wr;
  logic [NUM_SPR-1:0]   wr_sel;

  assign cfg_in = '{en: cfg_en, x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h, base: cfg_base};
  assign cfg_wr = cfg_we && ({1'b0, cfg_id} < SPR_LIM);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_SPR; i++)
      wr_sel[i] = cfg_wr && (cfg_id == 2'(i));
  end

  // A write coinciding with frame_start bypasses the shadow so it goes live immediately.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      cfg_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        if (wr_sel[i])
          shadow[i] <= cfg_in;
        if (frame_start)
          active[i] <= wr_sel[i] ? cfg_in : shadow[i];
      end
      if (frame_start)
        cfg_pending <= 1'b0;
      else if (cfg_wr)
        cfg_pending <= 1'b1;
    end
  end

  // ---- stage p0: combinational hit test and priority select on the active config
  logic              hit_p0;
  logic [1:0]        id_p0;
  logic [9:0]        selx_p0;
  logic [9:0]        sely_p0;
  logic [6:0]        selw_p0;
  logic [ADDR_W-1:0] selb_p0;

  always_comb begin
    hit_p0  = 1'b0;
    id_p0   = '0;
    selx_p0 = '0;
    sely_p0 = '0;
    selw_p0 = '0;
    selb_p0 = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (spr_hit(active[i], DrawX, DrawY)) begin
        hit_p0  = 1'b1;
        id_p0   = 2'(i);
        selx_p0 = active[i].x;
        sely_p0 = active[i].y;
        selw_p0 = active[i].w;
        selb_p0 = active[i].base;
      end
    end
  end

  // ---- stage p1: winner, offsets and the winner's geometry captured together
  logic              vld_p1;
  logic              hit_p1;
  logic [1:0]        id_p1;
  logic [9:0]        dx_p1;
  logic [9:0]        dy_p1;
  logic [6:0]        w_p1;
  logic [ADDR_W-1:0] base_p1;
  logic [9:0]        x_p1;
  logic [9:0]        y_p1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1  <= 1'b0;
      hit_p1  <= 1'b0;
      id_p1   <= '0;
      dx_p1   <= '0;
      dy_p1   <= '0;
      w_p1    <= '0;
      base_p1 <= '0;
      x_p1    <= '0;
      y_p1    <= '0;
    end else begin
      vld_p1  <= pix_en;
      hit_p1  <= hit_p0;
      id_p1   <= id_p0;
      dx_p1   <= DrawX - selx_p0;
      dy_p1   <= DrawY - sely_p0;
      w_p1    <= selw_p0;
      base_p1 <= selb_p0;
      x_p1    <= DrawX;
      y_p1    <= DrawY;
    end
  end

  // ---- stage p2: ROM address issue
  logic       vld_p2;
  logic       hit_p2;
  logic [1:0] id_p2;
  logic [9:0] x_p2;
  logic [9:0] y_p2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      vld_p2   <= 1'b0;
      hit_p2   <= 1'b0;
      id_p2    <= '0;
      x_p2     <= '0;
      y_p2     <= '0;
    end else begin
      rom_addr <= (vld_p1 && hit_p1) ? fetch_addr(base_p1, dy_p1, w_p1, dx_p1) : '0;
      vld_p2   <= vld_p1;
      hit_p2   <= hit_p1;
      id_p2    <= id_p1;
      x_p2     <= x_p1;
      y_p2     <= y_p1;
    end
  end

  // ---- stage p3: delay line matching the ROM read latency
  logic       vld_p3 [ROM_LAT];
  logic       hit_p3 [ROM_LAT];
  logic [1:0] id_p3  [ROM_LAT];
  logic [9:0] x_p3   [ROM_LAT];
  logic [9:0] y_p3   [ROM_LAT];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        vld_p3[k] <= 1'b0;
        hit_p3[k] <= 1'b0;
        id_p3[k]  <= '0;
        x_p3[k]   <= '0;
        y_p3[k]   <= '0;
      end
    end else begin
      for (int k = ROM_LAT - 1; k > 0; k--) begin
        vld_p3[k] <= vld_p3[k-1];
        hit_p3[k] <= hit_p3[k-1];
        id_p3[k]  <= id_p3[k-1];
        x_p3[k]   <= x_p3[k-1];
        y_p3[k]   <= y_p3[k-1];
      end
      vld_p3[0] <= vld_p2;
      hit_p3[0] <= hit_p2;
      id_p3[0]  <= id_p2;
      x_p3[0]   <= x_p2;
      y_p3[0]   <= y_p2;
    end
  end

  assign hit_out = vld_p3[ROM_LAT-1] & hit_p3[ROM_LAT-1];
  assign hit_id  = id_p3[ROM_LAT-1];
  assign X_out   = x_p3[ROM_LAT-1];
  assign Y_out   = y_p3[ROM_LAT-1];

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Bench for sprite_fetch_scheduler: a reference model feeds a latency-aligned scoreboard,
// and scenario tasks check the hand-computed values of each feature.
module tb_sprite_fetch_scheduler;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_id = '0;
  logic        cfg_en = 1'b0;
  logic [9:0]  cfg_x = '0;
  logic [9:0]  cfg_y = '0;
  logic [6:0]  cfg_w = '0;
  logic [6:0]  cfg_h = '0;
  logic [18:0] cfg_base = '0;
  logic        cfg_pending;
  logic [18:0] rom_addr;
  logic        hit_out;
  logic [1:0]  hit_id;
  logic [9:0]  X_out;
  logic [9:0]  Y_out;

  int checks = 0;
  int failures = 0;

  sprite_fetch_scheduler dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_en(pix_en),
    .DrawX(DrawX), .DrawY(DrawY), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_en(cfg_en),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_base(cfg_base),
    .cfg_pending(cfg_pending), .rom_addr(rom_addr), .hit_out(hit_out), .hit_id(hit_id),
    .X_out(X_out), .Y_out(Y_out)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [6:0]  w;
    logic [6:0]  h;
    logic [18:0] base;
  } mcfg_t;

  typedef struct packed {
    logic        hit;
    logic [1:0]  id;
    logic [18:0] addr;
    logic [9:0]  x;
    logic [9:0]  y;
  } exp_t;

  mcfg_t m_sh  [3];
  mcfg_t m_act [3];
  logic  m_pend = 1'b0;
  exp_t  q_addr [$];
  exp_t  q_out  [$];

  function automatic exp_t model_pix(logic en, logic [9:0] px, logic [9:0] py);
    exp_t  e;
    mcfg_t c;
    e = '0;
    e.x = px;
    e.y = py;
    if (en) begin
      for (int i = 0; i < 3; i++) begin
        c = m_act[i];
        if (!e.hit && c.en && c.w != 0 && c.h != 0 &&
            int'(px) >= int'(c.x) && int'(px) < int'(c.x) + int'(c.w) &&
            int'(py) >= int'(c.y) && int'(py) < int'(c.y) + int'(c.h)) begin
          e.hit  = 1'b1;
          e.id   = 2'(i);
          e.addr = 19'(int'(c.base) + (int'(py) - int'(c.y)) * int'(c.w) + (int'(px) - int'(c.x)));
        end
      end
    end
    return e;
  endfunction

  // Reference model: samples inputs at each rising edge.
  initial begin
    mcfg_t nc;
    exp_t  e;
    for (int i = 0; i < 3; i++) begin
      m_sh[i] = '0;
      m_act[i] = '0;
    end
    forever begin
      @(posedge Clk);
      if (Reset) begin
        q_addr.delete();
        q_out.delete();
        for (int i = 0; i < 2; i++) q_addr.push_back('0);
        for (int i = 0; i < 4; i++) q_out.push_back('0);
        for (int i = 0; i < 3; i++) begin
          m_sh[i] = '0;
          m_act[i] = '0;
        end
        m_pend = 1'b0;
      end else begin
        e = model_pix(pix_en, DrawX, DrawY);
        q_addr.push_back(e);
        q_out.push_back(e);
        nc = '{en: cfg_en, x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h, base: cfg_base};
        for (int i = 0; i < 3; i++) begin
          if (frame_start)
            m_act[i] = (cfg_we && cfg_id == 2'(i)) ? nc : m_sh[i];
          if (cfg_we && cfg_id == 2'(i))
            m_sh[i] = nc;
        end
        if (frame_start) m_pend = 1'b0;
        else if (cfg_we && cfg_id != 2'd3) m_pend = 1'b1;
      end
    end
  end

  // Scoreboard: rom_addr two edges after sampling, aligned outputs four edges after.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (q_addr.size() >= 2) begin
        e = q_addr.pop_front();
        checks++;
        if (rom_addr !== e.addr) begin
          failures++;
          $display("FAIL sb_rom_addr t=%0t got=%h exp=%h", $time, rom_addr, e.addr);
        end
      end
      if (q_out.size() >= 4) begin
        e = q_out.pop_front();
        checks++;
        if (hit_out !== e.hit || (e.hit && hit_id !== e.id) || X_out !== e.x || Y_out !== e.y) begin
          failures++;
          $display("FAIL sb_out t=%0t got hit=%b id=%0d x=%0d y=%0d exp hit=%b id=%0d x=%0d y=%0d",
                   $time, hit_out, hit_id, X_out, Y_out, e.hit, e.id, e.x, e.y);
        end
      end
      checks++;
      if (cfg_pending !== m_pend) begin
        failures++;
        $display("FAIL sb_pending t=%0t got=%b exp=%b", $time, cfg_pending, m_pend);
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_pix(input logic [9:0] x, input logic [9:0] y);
    pix_en = 1'b1;
    DrawX  = x;
    DrawY  = y;
  endtask

  task automatic write_cfg(input logic [1:0] id, input logic en, input logic [9:0] x,
                           input logic [9:0] y, input logic [6:0] w, input logic [6:0] h,
                           input logic [18:0] base, input logic commit);
    cfg_we = 1'b1; cfg_id = id; cfg_en = en; cfg_x = x; cfg_y = y;
    cfg_w = w; cfg_h = h; cfg_base = base; frame_start = commit;
    cyc();
    cfg_we = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic commit_cfg();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic h,
                       output logic [1:0] id, output logic [18:0] a,
                       output logic [9:0] xo, output logic [9:0] yo);
    drive_pix(x, y);
    cyc();
    pix_en = 1'b0;
    cyc();
    a = rom_addr;
    cyc();
    cyc();
    h  = hit_out;
    id = hit_id;
    xo = X_out;
    yo = Y_out;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive_pix(10'd5, 10'd5);
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (hit_out !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit_out); end
      checks++;
      if (rom_addr !== 19'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", rom_addr); end
      checks++;
      if (cfg_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", cfg_pending); end
    end
    Reset  = 1'b0;
    pix_en = 1'b0;
    cyc();
  endtask

  task automatic test_single_hit();
    logic h; logic [1:0] id; logic [18:0] a; logic [9:0] xo, yo;
    write_cfg(2'd0, 1'b1, 10'd100, 10'd50, 7'd32, 7'd24, 19'h1000, 1'b1);
    probe(10'd110, 10'd60, h, id, a, xo, yo);
    checks++;
    if (a !== 19'h114A) begin failures++; $display("FAIL single_addr got=%h exp=114a", a); end
    checks++;
    if (h !== 1'b1 || id !== 2'd0 || xo !== 10'd110 || yo !== 10'd60) begin
      failures++;
      $display("FAIL single_out got hit=%b id=%0d x=%0d y=%0d exp hit=1 id=0 x=110 y=60", h, id, xo, yo);
    end
  endtask

  task automatic test_edges();
    logic [9:0] px [4];
    logic [9:0] py [4];
    logic       ex [4];
    px = '{10'd131, 10'd132, 10'd99, 10'd110};
    py = '{10'd73, 10'd73, 10'd60, 10'd74};
    ex = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive_pix(px[i], py[i]);
      else pix_en = 1'b0;
      cyc();
      if (i >= 3) begin
        checks++;
        if (hit_out !== ex[i-3]) begin
          failures++;
          $display("FAIL edge_%0d got=%b exp=%b", i - 3, hit_out, ex[i-3]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (i < 46) drive_pix(10'(95 + i), 10'd60);
      else pix_en = 1'b0;
      cyc();
      if (hit_out === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 32) begin failures++; $display("FAIL b2b_hits got=%0d exp=32", cnt); end
  endtask

  task automatic test_priority();
    logic h; logic [1:0] id; logic [18:0] a; logic [9:0] xo, yo;
    write_cfg(2'd0, 1'b1, 10'd190, 10'd190, 7'd20, 7'd20, 19'h2000, 1'b0);
    write_cfg(2'd1, 1'b1, 10'd195, 10'd195, 7'd30, 7'd30, 19'h3000, 1'b1);
    probe(10'd200, 10'd200, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b1 || id !== 2'd0 || a !== 19'h20D2) begin
      failures++;
      $display("FAIL prio_both got hit=%b id=%0d addr=%h exp hit=1 id=0 addr=20d2", h, id, a);
    end
    write_cfg(2'd0, 1'b0, 10'd190, 10'd190, 7'd20, 7'd20, 19'h2000, 1'b1);
    probe(10'd200, 10'd200, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b1 || id !== 2'd1 || a !== 19'h309B) begin
      failures++;
      $display("FAIL prio_spr1 got hit=%b id=%0d addr=%h exp hit=1 id=1 addr=309b", h, id, a);
    end
    write_cfg(2'd1, 1'b0, 10'd195, 10'd195, 7'd30, 7'd30, 19'h3000, 1'b1);
  endtask

  task automatic test_commit();
    logic h; logic [1:0] id; logic [18:0] a; logic [9:0] xo, yo;
    write_cfg(2'd2, 1'b1, 10'd400, 10'd300, 7'd16, 7'd16, 19'h5000, 1'b0);
    checks++;
    if (cfg_pending !== 1'b1) begin failures++; $display("FAIL commit_pend_set got=%b exp=1", cfg_pending); end
    probe(10'd405, 10'd305, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL commit_shadow_only got=%b exp=0", h); end
    commit_cfg();
    checks++;
    if (cfg_pending !== 1'b0) begin failures++; $display("FAIL commit_pend_clr got=%b exp=0", cfg_pending); end
    probe(10'd405, 10'd305, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b1 || id !== 2'd2 || a !== 19'h5055) begin
      failures++;
      $display("FAIL commit_live got hit=%b id=%0d addr=%h exp hit=1 id=2 addr=5055", h, id, a);
    end
    write_cfg(2'd2, 1'b1, 10'd450, 10'd300, 7'd16, 7'd16, 19'h5000, 1'b1);
    checks++;
    if (cfg_pending !== 1'b0) begin failures++; $display("FAIL commit_same_pend got=%b exp=0", cfg_pending); end
    probe(10'd455, 10'd305, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b1 || id !== 2'd2 || a !== 19'h5055) begin
      failures++;
      $display("FAIL commit_same_live got hit=%b id=%0d addr=%h exp hit=1 id=2 addr=5055", h, id, a);
    end
    probe(10'd405, 10'd305, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL commit_old_pos got=%b exp=0", h); end
  endtask

  task automatic test_clip();
    logic h; logic [1:0] id; logic [18:0] a; logic [9:0] xo, yo;
    write_cfg(2'd0, 1'b1, 10'd620, 10'd100, 7'd40, 7'd10, 19'h0, 1'b1);
    probe(10'd639, 10'd105, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b1 || a !== 19'd219) begin
      failures++;
      $display("FAIL clip_639 got hit=%b addr=%0d exp hit=1 addr=219", h, a);
    end
    probe(10'd620, 10'd105, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b1 || a !== 19'd200) begin
      failures++;
      $display("FAIL clip_620 got hit=%b addr=%0d exp hit=1 addr=200", h, a);
    end
    probe(10'd619, 10'd105, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL clip_619 got=%b exp=0", h); end
    write_cfg(2'd1, 1'b1, 10'd300, 10'd100, 7'd0, 7'd10, 19'h100, 1'b1);
    probe(10'd300, 10'd105, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL zero_width got=%b exp=0", h); end
  endtask

  task automatic test_invalid_id();
    logic h; logic [1:0] id; logic [18:0] a; logic [9:0] xo, yo;
    write_cfg(2'd3, 1'b1, 10'd0, 10'd0, 7'd100, 7'd100, 19'h0, 1'b0);
    checks++;
    if (cfg_pending !== 1'b0) begin failures++; $display("FAIL badid_pend got=%b exp=0", cfg_pending); end
    commit_cfg();
    probe(10'd10, 10'd10, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL badid_hit got=%b exp=0", h); end
  endtask

  task automatic test_reset_midflight();
    logic h; logic [1:0] id; logic [18:0] a; logic [9:0] xo, yo;
    drive_pix(10'd630, 10'd105);
    cyc();
    drive_pix(10'd631, 10'd105);
    cyc();
    Reset = 1'b1;
    drive_pix(10'd632, 10'd105);
    cyc();
    Reset  = 1'b0;
    pix_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (hit_out !== 1'b0) begin failures++; $display("FAIL midreset_stale_%0d got=%b exp=0", i, hit_out); end
    end
    probe(10'd630, 10'd105, h, id, a, xo, yo);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL midreset_cfg got=%b exp=0", h); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_edges();
    test_back_to_back();
    test_priority();
    test_commit();
    test_clip();
    test_invalid_id();
    test_reset_midflight();
    repeat (4) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
